// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART with 16-entry TX/RX FIFOs and a registered level interrupt.
// Define UART_LOOPBACK_EN to add CTRL.b2 internal loopback (TX serial feeds RX, uart_tx held high).
module io_uart #(
  parameter logic [15:0] BASE_ADDR  = 16'h0100,
  parameter logic [15:0] CLK_DIV    = 16'd868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_r,
  input  logic        io_w,
  input  logic [15:0] io_addr,
  inout  wire  [31:0] io_data,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
`ifdef UART_LOOPBACK_EN
  localparam int CW = 3;
`else
  localparam int CW = 2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          w_sel, w_rd, w_wr, w_stat_rd, w_unused;
  logic [1:0]    w_reg;
  logic [31:0]   w_rdata;
  logic [CW-1:0] r_ctrl;
  logic [15:0]   r_div;
  logic          r_irq, r_ovr, r_ferr;

  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW:0]   r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic          w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic          w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;

  state_t        r_tx_state, w_tx_next, r_rx_state, w_rx_next;
  logic [15:0]   r_tx_cnt, r_rx_cnt;
  logic [2:0]    r_tx_bit, r_rx_bit;
  logic [7:0]    r_tx_shift, r_rx_shift;
  logic          w_tx_tick, w_tx_serial, w_rx_tick, w_rx_in, w_rx_fall;
  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  logic          w_rx_stop_ok, w_rx_ferr, w_rx_ovr;

  assign w_sel     = (io_addr[15:4] == BASE_ADDR[15:4]);
  assign w_reg     = io_addr[3:2];
  assign w_rd      = io_r & w_sel;
  assign w_wr      = io_w & w_sel & ~io_r;
  assign w_stat_rd = w_rd & (w_reg == 2'd1);
  assign w_unused  = &{1'b0, io_addr[1:0], io_data[31:16]};

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);

  assign w_tx_push = w_wr & (w_reg == 2'd0) & ~w_tx_full;
  assign w_rx_pop  = w_rd & (w_reg == 2'd0) & ~w_rx_empty;

  assign w_tx_tick   = (r_tx_cnt == 16'd0);
  assign w_tx_serial = (r_tx_state == S_START) ? 1'b0 :
                       (r_tx_state == S_DATA)  ? r_tx_shift[0] : 1'b1;

`ifdef UART_LOOPBACK_EN
  assign w_rx_in = r_ctrl[2] ? w_tx_serial : uart_rx;
  assign uart_tx = r_ctrl[2] | w_tx_serial;
`else
  assign w_rx_in = uart_rx;
  assign uart_tx = w_tx_serial;
`endif

  assign w_rx_tick    = (r_rx_cnt == 16'd0);
  assign w_rx_fall    = r_rx_s3 & ~r_rx_s2;
  assign w_rx_stop_ok = (r_rx_state == S_STOP) & w_rx_tick & r_rx_s2;
  assign w_rx_ferr    = (r_rx_state == S_STOP) & w_rx_tick & ~r_rx_s2;
  // A full FIFO refuses the byte even if a pop happens in the same cycle.
  assign w_rx_push    = w_rx_stop_ok & ~w_rx_full;
  assign w_rx_ovr     = w_rx_stop_ok & w_rx_full;

  always_comb begin
    w_rdata = 32'h0;
    case (w_reg)
      2'd0: w_rdata = w_rx_empty ? 32'h0 : {1'b1, 23'b0, r_rx_mem[r_rx_rp[AW-1:0]]};
      2'd1: w_rdata = {26'b0, r_ferr, r_ovr, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
      2'd2: w_rdata = {{(32-CW){1'b0}}, r_ctrl};
      default: w_rdata = {16'b0, r_div};
    endcase
  end

  assign io_data = w_rd ? w_rdata : 32'bz;
  assign irq     = r_irq;

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      S_IDLE:  if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_next = S_START; end
      S_START: if (w_tx_tick) w_tx_next = S_DATA;
      S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = S_STOP;
      default: if (w_tx_tick) begin
        // Chain straight into the next start bit when more data is queued.
        if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_next = S_START; end
        else w_tx_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
      S_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = S_STOP;
      default: if (w_rx_tick) w_rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= S_IDLE;
      r_rx_state <= S_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
      r_rx_state <= w_rx_next;
    end
  end

  // Baud counters reload from DIV only at bit boundaries, so DIV writes never stretch a bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
    end else begin
      if (w_tx_pop || (r_tx_state != S_IDLE && w_tx_tick)) r_tx_cnt <= r_div - 16'd1;
      else if (r_tx_state != S_IDLE)                       r_tx_cnt <= r_tx_cnt - 16'd1;
      if (r_tx_state != S_DATA) r_tx_bit <= '0;
      else if (w_tx_tick)       r_tx_bit <= r_tx_bit + 3'd1;
      r_rx_s1 <= w_rx_in;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      if (r_rx_state == S_IDLE) begin
        if (w_rx_fall) r_rx_cnt <= (r_div >> 1) - 16'd1;
      end else if (w_rx_tick) r_rx_cnt <= r_div - 16'd1;
      else                    r_rx_cnt <= r_rx_cnt - 16'd1;
      if (r_rx_state != S_DATA) r_rx_bit <= '0;
      else if (w_rx_tick)       r_rx_bit <= r_rx_bit + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl  <= '0;
      r_div   <= CLK_DIV;
      r_irq   <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_wr && w_reg == 2'd2) r_ctrl <= io_data[CW-1:0];
      if (w_wr && w_reg == 2'd3) r_div <= (io_data[15:0] < 16'd2) ? 16'd2 : io_data[15:0];
      if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_ONE;
      if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_ONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_ONE;
      // A new event in the same cycle as the clearing STATUS read keeps the flag set.
      r_ovr  <= w_rx_ovr  | (r_ovr  & ~w_stat_rd);
      r_ferr <= w_rx_ferr | (r_ferr & ~w_stat_rd);
      r_irq  <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty & (r_tx_state == S_IDLE));
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= io_data[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_shift;
    if (w_tx_pop)  r_tx_shift <= r_tx_mem[r_tx_rp[AW-1:0]];
    else if (r_tx_state == S_DATA && w_tx_tick) r_tx_shift <= {1'b0, r_tx_shift[7:1]};
    if (r_rx_state == S_DATA && w_rx_tick) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
  end

endmodule
